// File: rtl/alu_pkg.sv
// Shared ALU opcode encodings for the execution unit, sequencer and checker.
package alu_pkg;

  localparam logic [3:0] OP_PASS = 4'd0;
  localparam logic [3:0] OP_ADD  = 4'd1;
  localparam logic [3:0] OP_SUB  = 4'd2;
  localparam logic [3:0] OP_RSB  = 4'd3;
  localparam logic [3:0] OP_AND  = 4'd4;
  localparam logic [3:0] OP_OR   = 4'd5;
  localparam logic [3:0] OP_XOR  = 4'd6;
  localparam logic [3:0] OP_NOT  = 4'd7;
  localparam logic [3:0] OP_ADC  = 4'd8;
  localparam logic [3:0] OP_SBC  = 4'd9;
  localparam logic [3:0] OP_SHL  = 4'd10;
  localparam logic [3:0] OP_SHR  = 4'd11;
  localparam logic [3:0] OP_ASR  = 4'd12;
  localparam logic [3:0] OP_ROL  = 4'd13;
  localparam logic [3:0] OP_INC  = 4'd14;
  localparam logic [3:0] OP_CMP  = 4'd15;

endpackage

// File: rtl/alu_exec_core.sv
// Combinational ALU datapath: {a, b, sel, cin} -> {y, n, z, c, v}.
// Ports:
//   a, b : W-bit operands
//   sel  : 4-bit opcode (alu_pkg OP_*)
//   cin  : architectural carry used by ADC/SBC
//   y    : W-bit result
//   n/z/c/v : negative, zero, carry (1 = no borrow on subtract), overflow
module alu_exec_core
  import alu_pkg::*;
#(
  parameter int unsigned W = 4
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [3:0]   sel,
  input  logic         cin,
  output logic [W-1:0] y,
  output logic         n,
  output logic         z,
  output logic         c,
  output logic         v
);

  // One shared adder; subtraction is x + ~y + 1, so carry-out means no borrow.
  logic [W-1:0] add_x;
  logic [W-1:0] add_y;
  logic         add_ci;
  logic [W:0]   sum;
  logic         ovf;
  logic [W-1:0] flag_val;

  always_comb begin
    add_x  = a;
    add_y  = b;
    add_ci = 1'b0;
    unique case (sel)
      OP_SUB, OP_CMP: begin add_y = ~b;  add_ci = 1'b1; end
      OP_RSB:         begin add_x = b;   add_y = ~a; add_ci = 1'b1; end
      OP_ADC:         begin add_ci = cin; end
      OP_SBC:         begin add_y = ~b;  add_ci = cin; end
      OP_INC:         begin add_y = '0;  add_ci = 1'b1; end
      default: ;
    endcase
  end

  assign sum = {1'b0, add_x} + {1'b0, add_y} + {{W{1'b0}}, add_ci};
  assign ovf = (add_x[W-1] == add_y[W-1]) && (sum[W-1] != add_x[W-1]);

  always_comb begin
    y = '0;
    c = 1'b0;
    v = 1'b0;
    unique case (sel)
      OP_PASS: y = a;
      OP_ADD, OP_SUB, OP_RSB, OP_ADC, OP_SBC, OP_INC: begin
        y = sum[W-1:0];
        c = sum[W];
        v = ovf;
      end
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      OP_NOT:  y = ~a;
      OP_SHL:  begin y = {a[W-2:0], 1'b0};   c = a[W-1]; end
      OP_SHR:  begin y = {1'b0, a[W-1:1]};   c = a[0];   end
      OP_ASR:  begin y = {a[W-1], a[W-1:1]}; c = a[0];   end
      OP_ROL:  begin y = {a[W-2:0], a[W-1]}; c = a[W-1]; end
      OP_CMP:  begin y = a; c = sum[W]; v = ovf; end
      default: ;
    endcase
  end

  // CMP reports N/Z of the difference while returning A unchanged.
  assign flag_val = (sel == OP_CMP) ? sum[W-1:0] : y;
  assign n = flag_val[W-1];
  assign z = (flag_val == '0);

endmodule

// File: rtl/alu_exec_unit.sv
// Sequential ALU responder: accepts {a, b, sel} over valid/ready, returns the
// result and flags one cycle later from a registered response channel, and
// keeps an architectural carry flag for ADC/SBC chains.
// Ports:
//   clk, rst            : clock, synchronous active-high reset
//   req_valid/req_ready : request handshake; req_a, req_b, req_sel payload
//   clear_carry         : clears the carry flag (an op accepted that cycle sees 0)
//   rsp_valid/rsp_ready : response handshake; rsp_y, rsp_n/z/c/v payload
//   op_count            : accepted requests since reset, wrapping
module alu_exec_unit
  import alu_pkg::*;
#(
  parameter int unsigned W     = 4,
  parameter int unsigned CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [W-1:0]     req_a,
  input  logic [W-1:0]     req_b,
  input  logic [3:0]       req_sel,
  input  logic             clear_carry,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [W-1:0]     rsp_y,
  output logic             rsp_n,
  output logic             rsp_z,
  output logic             rsp_c,
  output logic             rsp_v,
  output logic [CNT_W-1:0] op_count
);

  logic         carry_flag;
  logic         accept;
  logic         core_cin;
  logic [W-1:0] core_y;
  logic         core_n;
  logic         core_z;
  logic         core_c;
  logic         core_v;

  assign req_ready = ~rsp_valid | rsp_ready;
  assign accept    = req_valid & req_ready;
  assign core_cin  = clear_carry ? 1'b0 : carry_flag;

  alu_exec_core #(.W(W)) u_core (
    .a   (req_a),
    .b   (req_b),
    .sel (req_sel),
    .cin (core_cin),
    .y   (core_y),
    .n   (core_n),
    .z   (core_z),
    .c   (core_c),
    .v   (core_v)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_valid  <= 1'b0;
      rsp_y      <= '0;
      rsp_n      <= 1'b0;
      rsp_z      <= 1'b0;
      rsp_c      <= 1'b0;
      rsp_v      <= 1'b0;
      carry_flag <= 1'b0;
      op_count   <= '0;
    end else if (accept) begin
      rsp_valid  <= 1'b1;
      rsp_y      <= core_y;
      rsp_n      <= core_n;
      rsp_z      <= core_z;
      rsp_c      <= core_c;
      rsp_v      <= core_v;
      carry_flag <= core_c;
      op_count   <= op_count + CNT_W'(1);
    end else begin
      if (rsp_ready)   rsp_valid  <= 1'b0;
      if (clear_carry) carry_flag <= 1'b0;
    end
  end

endmodule

// File: tb/tb_alu_exec_unit.sv
module tb_alu_exec_unit;
  import alu_pkg::*;

  localparam int unsigned W     = 4;
  localparam int unsigned CNT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             req_valid;
  logic             req_ready;
  logic [W-1:0]     req_a;
  logic [W-1:0]     req_b;
  logic [3:0]       req_sel;
  logic             clear_carry;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [W-1:0]     rsp_y;
  logic             rsp_n;
  logic             rsp_z;
  logic             rsp_c;
  logic             rsp_v;
  logic [CNT_W-1:0] op_count;

  always #5 clk = ~clk;

  alu_exec_unit #(.W(W), .CNT_W(CNT_W)) dut (
    .clk         (clk),
    .rst         (rst),
    .req_valid   (req_valid),
    .req_ready   (req_ready),
    .req_a       (req_a),
    .req_b       (req_b),
    .req_sel     (req_sel),
    .clear_carry (clear_carry),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_y       (rsp_y),
    .rsp_n       (rsp_n),
    .rsp_z       (rsp_z),
    .rsp_c       (rsp_c),
    .rsp_v       (rsp_v),
    .op_count    (op_count)
  );

  int unsigned n_vec = 0;
  int unsigned n_err = 0;

  logic [7:0] sb_q[$];   // expected {y[3:0], n, z, c, v}
  logic       m_cf;
  int         m_cnt;

  task automatic chk(input string tag, input int obs, input int exp);
    n_vec++;
    if (obs != exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Reference model in integer arithmetic, independent of the adder structure.
  function automatic logic [7:0] model(input logic [3:0] sel, input logic [3:0] a,
                                       input logic [3:0] b, input logic cin);
    int ua, ub, sa, sb, r, f, sr, bw;
    logic c, v, arith;
    logic [3:0] y, fv;
    ua = int'(a); ub = int'(b);
    sa = (ua >= 8) ? ua - 16 : ua;
    sb = (ub >= 8) ? ub - 16 : ub;
    c = 1'b0; arith = 1'b0; sr = 0; r = 0; f = 0;
    case (sel)
      OP_PASS: r = ua;
      OP_ADD:  begin r = ua + ub; c = (r > 15); sr = sa + sb; arith = 1; end
      OP_SUB:  begin r = ua - ub; c = (ua >= ub); sr = sa - sb; arith = 1; end
      OP_RSB:  begin r = ub - ua; c = (ub >= ua); sr = sb - sa; arith = 1; end
      OP_AND:  r = int'(a & b);
      OP_OR:   r = int'(a | b);
      OP_XOR:  r = int'(a ^ b);
      OP_NOT:  r = 15 - ua;
      OP_ADC:  begin r = ua + ub + int'(cin); c = (r > 15); sr = sa + sb + int'(cin); arith = 1; end
      OP_SBC:  begin bw = 1 - int'(cin); r = ua - ub - bw; c = (r >= 0); sr = sa - sb - bw; arith = 1; end
      OP_SHL:  begin r = ua * 2; c = (ua >= 8); end
      OP_SHR:  begin r = ua / 2; c = (ua % 2 == 1); end
      OP_ASR:  begin r = ua / 2 + ((ua >= 8) ? 8 : 0); c = (ua % 2 == 1); end
      OP_ROL:  begin r = (ua * 2) % 16 + ((ua >= 8) ? 1 : 0); c = (ua >= 8); end
      OP_INC:  begin r = ua + 1; c = (r > 15); sr = sa + 1; arith = 1; end
      default: begin r = ua - ub; c = (ua >= ub); sr = sa - sb; arith = 1; end // CMP
    endcase
    f = r;
    if (sel == OP_CMP) r = ua;
    y  = 4'(r & 15);
    fv = 4'(f & 15);
    v  = arith && (sr > 7 || sr < -8);
    return {y, fv[3], (fv == 4'd0), c, v};
  endfunction

  // One clock cycle: drive at negedge, check and update the scoreboard, return before posedge.
  task automatic step(input logic v, input logic [3:0] sel, input logic [3:0] a,
                      input logic [3:0] b, input logic clr, input logic rr, input logic r);
    logic [7:0] e;
    logic       exp_ready;
    @(negedge clk);
    rst = r; req_valid = v; req_sel = sel; req_a = a; req_b = b;
    clear_carry = clr; rsp_ready = rr;
    #1;
    chk("rsp_valid", int'(rsp_valid), int'(sb_q.size() != 0));
    chk("op_count", int'(op_count), m_cnt % (1 << CNT_W));
    if (r) begin
      sb_q.delete();
      m_cf  = 1'b0;
      m_cnt = 0;
    end else begin
      exp_ready = (sb_q.size() == 0) || rr;
      chk("req_ready", int'(req_ready), int'(exp_ready));
      if (rr && sb_q.size() != 0) begin
        e = sb_q.pop_front();
        chk("rsp", int'({rsp_y, rsp_n, rsp_z, rsp_c, rsp_v}), int'(e));
      end
      if (v && exp_ready) begin
        e = model(sel, a, b, clr ? 1'b0 : m_cf);
        sb_q.push_back(e);
        m_cf = e[1];
        m_cnt++;
      end else if (clr) begin
        m_cf = 1'b0;
      end
    end
  endtask

  // Check the response loaded at the coming edge against a hand-derived constant.
  task automatic peek(input string tag, input logic [7:0] exp);
    @(posedge clk);
    #1;
    chk(tag, int'({rsp_y, rsp_n, rsp_z, rsp_c, rsp_v}), int'(exp));
  endtask

  initial begin
    rst = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_sel = '0;
    clear_carry = 1'b0; rsp_ready = 1'b0;
    m_cf = 1'b0; m_cnt = 0;

    step(0, OP_PASS, 0, 0, 0, 0, 1);
    step(0, OP_PASS, 0, 0, 0, 0, 1);

    // ADD then carry-chained ADC on the very next cycle
    step(1, OP_ADD, 10, 15, 0, 1, 0); peek("add_10_15", {4'd9, 1'b1, 1'b0, 1'b1, 1'b0});
    step(1, OP_ADC, 0, 0, 0, 1, 0);   peek("adc_chain", {4'd1, 1'b0, 1'b0, 1'b0, 1'b0});

    // SBC after clear, SUB
    step(0, OP_PASS, 0, 0, 1, 1, 0);
    step(1, OP_SBC, 15, 15, 0, 1, 0); peek("sbc_15_15", {4'd15, 1'b1, 1'b0, 1'b0, 1'b0});
    step(1, OP_SUB, 5, 10, 0, 1, 0);  peek("sub_5_10", {4'd11, 1'b1, 1'b0, 1'b0, 1'b1});

    // CMP / INC / ROL
    step(1, OP_CMP, 13, 2, 0, 1, 0);  peek("cmp_13_2", {4'd13, 1'b1, 1'b0, 1'b1, 1'b0});
    step(1, OP_INC, 7, 0, 0, 1, 0);   peek("inc_7", {4'd8, 1'b1, 1'b0, 1'b0, 1'b1});
    step(1, OP_ROL, 9, 0, 0, 1, 0);   peek("rol_9", {4'd3, 1'b0, 1'b0, 1'b1, 1'b0});
    step(0, OP_PASS, 0, 0, 0, 1, 0);

    // Backpressure: one accept, then held for 3 cycles, then streaming
    step(1, OP_ADD, 3, 4, 0, 0, 0);
    for (int i = 0; i < 3; i++) begin
      step(1, OP_OR, 4'(i), 9, 0, 0, 0);
      chk("hold_y", int'(rsp_y), 7);
    end
    for (int i = 0; i < 20; i++)
      step(1, 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom), 0, 1, 0);
    step(0, OP_PASS, 0, 0, 0, 1, 0);

    // Reset in the middle of a pending response, with carry set
    step(1, OP_ADD, 15, 15, 0, 0, 0);
    step(1, OP_ADD, 1, 1, 0, 1, 1);
    step(1, OP_ADD, 1, 1, 0, 1, 1);
    step(1, OP_ADC, 0, 0, 0, 1, 0);   peek("adc_after_rst", {4'd0, 1'b0, 1'b1, 1'b0, 1'b0});
    step(0, OP_PASS, 0, 0, 0, 1, 0);

    // Counter wrap after 256 accepts from reset
    step(0, OP_PASS, 0, 0, 0, 1, 1);
    for (int i = 0; i < 256; i++)
      step(1, 4'($urandom_range(0, 15)), 4'($urandom), 4'($urandom),
           1'($urandom_range(0, 3) == 0), 1, 0);
    step(0, OP_PASS, 0, 0, 0, 1, 0);
    chk("wrap", int'(op_count), 0);

    // clear_carry coincident with ADC: op must see carry 0
    step(1, OP_ADD, 15, 1, 0, 1, 0);
    step(1, OP_ADC, 3, 4, 1, 1, 0);   peek("adc_clr", {4'd7, 1'b0, 1'b0, 1'b0, 1'b0});

    // Random mix of valid, backpressure and carry clears
    for (int i = 0; i < 300; i++)
      step(1'($urandom_range(0, 3) != 0), 4'($urandom_range(0, 15)), 4'($urandom),
           4'($urandom), 1'($urandom_range(0, 7) == 0), 1'($urandom_range(0, 2) != 0), 0);
    step(0, OP_PASS, 0, 0, 0, 1, 0);
    step(0, OP_PASS, 0, 0, 0, 1, 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
